// File: rtl/seq_detect_ctrl_if.sv
// Control, configuration and serial-stream bundle for seq_detect_ctrl.
// The master drives configuration, commands and bits; the slave returns match and status.
interface seq_detect_ctrl_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_threshold;
  logic               start;
  logic               stop;
  logic               x;
  logic               x_valid;
  logic               irq_clr;
  logic               z;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   match_count;
  logic               irq;
  logic               cfg_err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_threshold,
    output start, stop, x, x_valid, irq_clr,
    input  z, busy, done, match_count, irq, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_threshold,
    input  start, stop, x, x_valid, irq_clr,
    output z, busy, done, match_count, irq, cfg_err
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable Mealy serial sequence detector with arm/disarm control,
// saturating match counter and sticky threshold interrupt.
module seq_detect_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_e;

  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic [CNT_W-1:0]   threshold;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    pattern:   MAX_LEN'(4'b1001),
    len:       LEN_W'(4),
    overlap:   1'b0,
    threshold: '0
  };

  state_e             state_q, state_d;
  cfg_t               cfg_q, cfg_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_q, irq_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] window_c;
  logic [MAX_LEN-1:0] mask_c;
  logic               match_c;
  logic               z_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [LEN_W-1:0]   fill_inc_c;
  logic               thr_hit_c;
  logic               arm_c;
  logic               len_bad_c;

  // Mealy match: newest bit joins the history, only the low len bits are compared
  always_comb begin
    window_c = {hist_q, bus.x};
    mask_c   = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask_c[i] = (i < 32'(cfg_q.len));
    end
    match_c = (((window_c ^ cfg_q.pattern) & mask_c) == '0);
    z_c     = (state_q == ARMED) && bus.x_valid &&
              (fill_q >= (cfg_q.len - LEN_W'(1))) && match_c;
  end

  assign cnt_inc_c  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign fill_inc_c = (fill_q == LEN_W'(MAX_LEN - 1)) ? fill_q : fill_q + LEN_W'(1);
  assign arm_c      = bus.start && !bus.stop;
  assign len_bad_c  = (bus.cfg_len < LEN_W'(2)) || (bus.cfg_len > LEN_W'(MAX_LEN));

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    irq_d     = irq_q && !bus.irq_clr;
    cfg_err_d = 1'b0;
    thr_hit_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arm_c) begin
          state_d = ARMED;
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        if (bus.x_valid) begin
          // Non-overlapping mode discards the bits consumed by a match
          if (z_c && !cfg_q.overlap) begin
            hist_d = '0;
            fill_d = '0;
          end else begin
            hist_d = window_c[MAX_LEN-2:0];
            fill_d = fill_inc_c;
          end
          if (z_c) begin
            cnt_d     = cnt_inc_c;
            thr_hit_c = (cfg_q.threshold != '0) && (cnt_inc_c == cfg_q.threshold);
          end
        end
        if (bus.stop) begin
          state_d = IDLE;
        end else if (thr_hit_c) begin
          state_d = DONE;
        end
        if (thr_hit_c) begin
          irq_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.start) begin
          state_d = ARMED;
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.cfg_we) begin
      if ((state_q == ARMED) || len_bad_c) begin
        cfg_err_d = 1'b1;
      end else begin
        cfg_d = '{
          pattern:   bus.cfg_pattern,
          len:       bus.cfg_len,
          overlap:   bus.cfg_overlap,
          threshold: bus.cfg_threshold
        };
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cfg_q     <= CFG_RST;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.z           = z_c;
  assign bus.busy        = (state_q == ARMED);
  assign bus.done        = (state_q == DONE);
  assign bus.match_count = cnt_q;
  assign bus.irq         = irq_q;
  assign bus.cfg_err     = cfg_err_q;

endmodule
